// File: rtl/logic_unit_pipe.sv
// Pipelined two-operand bitwise logic unit with valid/ready flow control.
// Every stage moves in lockstep, and the final stage registers Out together with its zero, parity and popcount flags.
module logic_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] popcnt
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOT  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic             advance;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] data_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0] stage_in_data [STAGES];
    logic [STAGES-1:0] stage_in_valid;
    logic [WIDTH-1:0] last_in;
    logic             zero_d, zero_q;
    logic             parity_d, parity_q;
    logic [CNT_W-1:0] popcnt_d, popcnt_q;

    // The whole pipeline stalls only when a finished result is waiting on the consumer.
    assign advance  = ~valid_q[STAGES-1] | out_ready;
    assign in_ready = advance;

    always_comb begin
        result_d = '0;
        case (op_e'(op))
            OP_AND:  result_d = In1 & In2;
            OP_OR:   result_d = In1 | In2;
            OP_XOR:  result_d = In1 ^ In2;
            OP_NOR:  result_d = ~(In1 | In2);
            OP_NAND: result_d = ~(In1 & In2);
            OP_XNOR: result_d = ~(In1 ^ In2);
            OP_NOT:  result_d = ~In1;
            OP_PASS: result_d = In1;
            default: result_d = '0;
        endcase
    end

    // Stage i loads from stage i-1, and stage 0 loads from the freshly computed result.
    always_comb begin
        stage_in_data[0]  = result_d;
        stage_in_valid[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            stage_in_data[i]  = data_q[i-1];
            stage_in_valid[i] = valid_q[i-1];
        end
    end

    // Flags are computed from the value entering the output register, so they always match Out.
    always_comb begin
        last_in  = stage_in_data[STAGES-1];
        zero_d   = (last_in == '0);
        parity_d = ^last_in;
        popcnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            popcnt_d = popcnt_d + CNT_W'(last_in[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
            popcnt_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else if (advance) begin
            // Bubbles move through the valid bits but leave stale data in place.
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= stage_in_valid[i];
                if (stage_in_valid[i]) begin
                    data_q[i] <= stage_in_data[i];
                end
            end
            if (stage_in_valid[STAGES-1]) begin
                zero_q   <= zero_d;
                parity_q <= parity_d;
                popcnt_q <= popcnt_d;
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign Out       = data_q[STAGES-1];
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign popcnt    = popcnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: directed sweeps plus randomized streams checked against a queue-based reference model.
// One 8-bit, 2-stage instance and two 16-bit corner instances (1 and 4 stages) share the clock and reset.
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [7:0] In1 = '0, In2 = '0, Out;
    logic [2:0] op = '0;
    logic       zero, parity;
    logic [3:0] popcnt;

    logic        cInValid = 1'b0, cOutReady = 1'b1;
    logic [15:0] cIn1 = '0, cIn2 = '0;
    logic [2:0]  cOp = '0;
    logic        cInReadyA, cOutValidA, cZeroA, cParityA;
    logic        cInReadyB, cOutValidB, cZeroB, cParityB;
    logic [15:0] cOutA, cOutB;
    logic [4:0]  cPopA, cPopB;

    int compared = 0;
    int mismatched = 0;

    logic_unit_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .In1(In1), .In2(In2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .Out(Out), .zero(zero), .parity(parity), .popcnt(popcnt)
    );

    logic_unit_pipe #(.WIDTH(16), .STAGES(1), .CNT_W(5)) dutS1 (
        .clk(clk), .rst_n(rst_n), .in_valid(cInValid), .in_ready(cInReadyA),
        .In1(cIn1), .In2(cIn2), .op(cOp), .out_valid(cOutValidA), .out_ready(cOutReady),
        .Out(cOutA), .zero(cZeroA), .parity(cParityA), .popcnt(cPopA)
    );

    logic_unit_pipe #(.WIDTH(16), .STAGES(4), .CNT_W(5)) dutS4 (
        .clk(clk), .rst_n(rst_n), .in_valid(cInValid), .in_ready(cInReadyB),
        .In1(cIn1), .In2(cIn2), .op(cOp), .out_valid(cOutValidB), .out_ready(cOutReady),
        .Out(cOutB), .zero(cZeroB), .parity(cParityB), .popcnt(cPopB)
    );

    // Reference behaviour of each op code, written straight from the op table.
    function automatic logic [63:0] modelOp(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a | b);
            3'd4: return ~(a & b);
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        compared++;
        if (Out !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_Out got %h want 00", Out); end
        compared++;
        if ({zero, parity, popcnt} !== 6'b0) begin
            mismatched++; $display("[TB] FAIL reset_flags got z=%b p=%b pc=%0d want all 0", zero, parity, popcnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_op_sweep();
        logic [7:0] expOut [8] = '{8'h24, 8'hBD, 8'h99, 8'h42, 8'hDB, 8'h66, 8'h5A, 8'hA5};
        int         expPop [8] = '{2, 6, 4, 2, 6, 4, 4, 4};
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k < 8);
            In1 = 8'hA5;
            In2 = 8'h3C;
            op = 3'(k);
            #1;
            compared++;
            if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL sweep_in_ready k=%0d got %b want 1", k, in_ready); end
            @(posedge clk);
            @(negedge clk);
            if (k >= 1 && k <= 8) begin
                compared++;
                if (out_valid !== 1'b1 || Out !== expOut[k-1]) begin
                    mismatched++; $display("[TB] FAIL sweep_out op=%0d got v=%b %h want v=1 %h", k-1, out_valid, Out, expOut[k-1]);
                end
                compared++;
                if (int'(popcnt) != expPop[k-1] || parity !== 1'b0 || zero !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL sweep_flags op=%0d got pc=%0d p=%b z=%b want pc=%0d p=0 z=0", k-1, popcnt, parity, zero, expPop[k-1]);
                end
            end else begin
                compared++;
                if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL sweep_bubble k=%0d got v=%b want 0", k, out_valid); end
            end
            if (k == 9) begin
                compared++;
                if (Out !== 8'hA5) begin mismatched++; $display("[TB] FAIL bubble_hold got %h want a5", Out); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_zero_flag();
        in_valid = 1'b1; In1 = 8'hFF; In2 = 8'h00; op = 3'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b1 || Out !== 8'h00) begin mismatched++; $display("[TB] FAIL zero_out got v=%b %h want v=1 00", out_valid, Out); end
        compared++;
        if (zero !== 1'b1 || parity !== 1'b0 || popcnt !== 4'd0) begin
            mismatched++; $display("[TB] FAIL zero_flags got z=%b p=%b pc=%0d want z=1 p=0 pc=0", zero, parity, popcnt);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [7:0] a [6], b [6], expQ [$], expected, prevOut;
        logic [2:0] o [6];
        int sent = 0, got = 0;
        logic prevStall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a[i] = 8'($urandom); b[i] = 8'($urandom); o[i] = 3'($urandom);
        end
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            in_valid  = (sent < 6);
            In1 = a[sent % 6]; In2 = b[sent % 6]; op = o[sent % 6];
            out_ready = !(cyc >= 3 && cyc < 7);
            #1;
            if (prevStall) begin
                compared++;
                if (out_valid !== 1'b1 || Out !== prevOut) begin
                    mismatched++; $display("[TB] FAIL stall_hold cyc=%0d got v=%b %h want v=1 %h", cyc, out_valid, Out, prevOut);
                end
            end
            if (out_valid && !out_ready) begin
                compared++;
                if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_in_ready cyc=%0d got %b want 0", cyc, in_ready); end
            end
            if (cyc >= 7) begin
                compared++;
                if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_gap cyc=%0d got v=%b want 1", cyc, out_valid); end
            end
            if (out_valid && out_ready) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++; $display("[TB] FAIL bp_dup got %h want nothing", Out);
                end else begin
                    expected = expQ.pop_front();
                    if (Out !== expected || int'(popcnt) != $countones(expected)) begin
                        mismatched++; $display("[TB] FAIL bp_order got %h pc=%0d want %h pc=%0d", Out, popcnt, expected, $countones(expected));
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expQ.push_back(modelOp(o[sent], {56'b0, a[sent]}, {56'b0, b[sent]}) & 64'hFF);
                sent++;
            end
            prevStall = out_valid && !out_ready;
            prevOut = Out;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        compared++;
        if (got != 6 || expQ.size() != 0) begin
            mismatched++; $display("[TB] FAIL bp_count got %0d left %0d want 6 left 0", got, expQ.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] expQ [$], expected, prevOut, ra, rb, tmp;
        logic [2:0] ro;
        logic pending = 1'b0, prevStall = 1'b0;
        logic [63:0] full;
        int consumed = 0;
        for (int cyc = 0; cyc < 320; cyc++) begin
            if (!pending) begin
                ra = 8'($urandom); rb = 8'($urandom); ro = 3'($urandom);
                in_valid = (cyc < 300) && ($urandom_range(0, 9) < 7);
            end
            In1 = ra; In2 = rb; op = ro;
            out_ready = (cyc >= 300) || ($urandom_range(0, 9) < 7);
            #1;
            if (prevStall) begin
                compared++;
                if (out_valid !== 1'b1 || Out !== prevOut) begin
                    mismatched++; $display("[TB] FAIL rnd_hold cyc=%0d got v=%b %h want v=1 %h", cyc, out_valid, Out, prevOut);
                end
            end
            if (out_valid && out_ready) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++; $display("[TB] FAIL rnd_dup cyc=%0d got %h want nothing", cyc, Out);
                end else begin
                    expected = expQ.pop_front();
                    if (Out !== expected || int'(popcnt) != $countones(expected) || parity !== ^expected
                        || zero !== (expected == 8'h00)) begin
                        mismatched++;
                        $display("[TB] FAIL rnd_result cyc=%0d got %h pc=%0d p=%b z=%b want %h pc=%0d", cyc, Out, popcnt,
                                 parity, zero, expected, $countones(expected));
                    end
                end
                consumed++;
            end
            if (in_valid && in_ready) begin
                full = modelOp(ro, {56'b0, ra}, {56'b0, rb});
                tmp = full[7:0];
                expQ.push_back(tmp);
            end
            pending = in_valid && !in_ready;
            compared++;
            if (expQ.size() > 2) begin mismatched++; $display("[TB] FAIL rnd_capacity got %0d want <=2", expQ.size()); end
            prevStall = out_valid && !out_ready;
            prevOut = Out;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        compared++;
        if (expQ.size() != 0 || consumed == 0) begin
            mismatched++; $display("[TB] FAIL rnd_drain got left=%0d consumed=%0d want left=0", expQ.size(), consumed);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; In1 = 8'h0F; In2 = 8'hF0; op = 3'd1;
        @(posedge clk);
        @(negedge clk);
        In1 = 8'h33; op = 3'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_inflight got v=%b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || Out !== 8'h00) begin
            mismatched++; $display("[TB] FAIL mid_reset got v=%b %h want v=0 00", out_valid, Out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_stale i=%0d got v=%b %h want v=0", i, out_valid, Out); end
        end
    endtask

    task automatic test_corners();
        int latA = 0, latB = 0;
        cInValid = 1'b1; cIn1 = 16'hFFFF; cIn2 = 16'h0001; cOp = 3'd2;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            cInValid = 1'b0;
            if (cOutValidA && latA == 0) begin
                latA = cyc;
                compared++;
                if (cOutA !== 16'hFFFE || cPopA !== 5'd15) begin
                    mismatched++; $display("[TB] FAIL s1_result got %h pc=%0d want fffe pc=15", cOutA, cPopA);
                end
            end
            if (cOutValidB && latB == 0) begin
                latB = cyc;
                compared++;
                if (cOutB !== 16'hFFFE || cPopB !== 5'd15) begin
                    mismatched++; $display("[TB] FAIL s4_result got %h pc=%0d want fffe pc=15", cOutB, cPopB);
                end
            end
        end
        compared++;
        if (latA != 1) begin mismatched++; $display("[TB] FAIL s1_latency got %0d want 1", latA); end
        compared++;
        if (latB != 4) begin mismatched++; $display("[TB] FAIL s4_latency got %0d want 4", latB); end
    endtask

    initial begin
        test_reset();
        test_op_sweep();
        test_zero_flag();
        test_backpressure();
        test_random();
        test_mid_reset();
        test_corners();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit for the DSP datapath; generalises the fixed 8-bit combinational NOR gate.
- Supports eight selectable two-operand logic operations at configurable width.
- Uses a configurable register depth with valid/ready flow control on both sides.
- Produces zero, parity and population-count flags alongside each result, for the sequencer and status logic.

Parameters:
- WIDTH, 8, operand and result width in bits (legal 2..64).
- STAGES, 2, pipeline register depth from accepted input to registered output (legal 1..4).
- CNT_W, 4, width of popcnt output; must satisfy 2^CNT_W > WIDTH (default suits WIDTH=8).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents a valid operation this cycle.
- in_ready  output  1  block can accept an operation this cycle.
- In1  input  WIDTH  operand A.
- In2  input  WIDTH  operand B.
- op  input  3  operation select, sampled with the operands.
- out_valid  output  1  Out and flags hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- Out  output  WIDTH  registered result.
- zero  output  1  Out == 0.
- parity  output  1  XOR-reduction of Out.
- popcnt  output  CNT_W  number of 1 bits in Out.

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - While rst_n=0, all stage valid bits, Out, zero, parity and popcnt are 0.
  - in_ready is 1 one cycle after rst_n deasserts (it is driven combinationally from the empty pipeline).
- Op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NOR.
  - 100 NAND, 101 XNOR, 110 NOT In1, 111 PASS In1.
  - In2 is ignored for 110 and 111.
- Input handshake:
  - An operation is accepted on a rising edge where in_valid=1 and in_ready=1.
  - In1, In2 and op are captured only on acceptance.
- Output handshake:
  - A result is consumed on a rising edge where out_valid=1 and out_ready=1.
  - out_valid, Out and the flags hold steady while out_valid=1 and out_ready=0.
- Pipeline:
  - STAGES registers, each holding a valid bit, data and op as needed.
  - Stage 1 computes the logic result from the captured operands.
  - The final stage registers Out and derives zero, parity and popcnt from the registered result, so flags always match Out.
  - Flags are valid in the same cycle as Out.
- Flow control (global-stall pipeline):
  - advance = ~out_valid | out_ready.
  - When advance=1, every stage loads from its predecessor; a bubble enters stage 1 if no input is accepted.
  - When advance=0, all stages hold.
  - in_ready = advance (combinational).
- Latency and throughput:
  - Latency is exactly STAGES cycles from acceptance to out_valid when out_ready stays 1.
  - Throughput is one result per cycle under continuous handshakes.
- Ordering: results emerge in acceptance order, no loss and no duplication.
- Bubbles: an invalid stage does not update Out; Out keeps its last value but out_valid=0.
- Simultaneous events: consume and accept on the same edge are both legal; the pipeline shifts by one.
- Stall with full pipeline:
  - in_ready=0; upstream must hold its data.
  - The block never drops an accepted operation.
- Reset mid-operation: all in-flight operations are discarded and out_valid drops to 0 immediately.
- STAGES=1: the operation is computed combinationally into the single output register.
- Arithmetic:
  - popcnt is an unsigned sum of result bits zero-extended to CNT_W.
  - No other width growth; all ops are bitwise over WIDTH.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release -> out_valid=0, Out=0, zero=0, popcnt=0; in_ready=1 after one cycle.
- Op sweep (WIDTH=8, STAGES=2, out_ready=1): In1=8'hA5, In2=8'h3C, op 0..7 on consecutive cycles -> Out = 24, BD, 99, 42, DB, 66, 5A, A5, each 2 cycles after acceptance.
  - Flags per result: popcnt 2,6,4,2,6,4,4,4; parity always 0.
  - zero is never set in the sweep.
- Zero flag: NOR with In1=FF, In2=00 -> Out=00, zero=1, parity=0, popcnt=0.
- Backpressure:
  - Stream 6 ops, hold out_ready=0 from cycle 3 for 4 cycles -> in_ready=0 once full.
  - Out is stable during the stall.
  - After release, all 6 results appear in order with no gaps or duplicates.
- Mid-stream reset: assert rst_n=0 with 2 ops in flight -> out_valid=0 at once; after release, no stale result ever appears.
- Parameter corners: WIDTH=16, STAGES=1 and STAGES=4, XOR of FFFF and 0001 -> Out=FFFE, popcnt=15 (CNT_W=5), latency 1 and 4 cycles respectively.
